// File: rtl/saf_pkg.sv
// Shared definitions for the spline adaptive filter update blocks:
// Q-format defaults, the update FSM state type and the rounding/clip helpers.
package saf_pkg;

  localparam int unsigned SafWidth = 16;
  localparam int unsigned SafQp    = 12;
  localparam int unsigned SafTaps  = 8;

  typedef logic signed [63:0] saf_acc_t;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } wu_state_e;

  // Half an LSB of the Q(qp) result; added before the arithmetic shift to round half up.
  function automatic saf_acc_t rnd(input int unsigned qp);
    return 64'sd1 <<< (qp - 1);
  endfunction

  function automatic saf_acc_t sat_to_width(input saf_acc_t v, input int unsigned w);
    saf_acc_t hi;
    saf_acc_t lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/w_update_bank_if.sv
// Request/response bundle of the weight-bank updater: one shared mu_error,
// a packed tap-input vector, and the committed packed weight vector.
interface w_update_bank_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAPS  = 8
);

  logic                     start;
  logic signed [WIDTH-1:0]  mu_error;
  logic [TAPS*WIDTH-1:0]    x_vec;
  logic                     freeze;
  logic                     busy;
  logic                     done;
  logic [TAPS*WIDTH-1:0]    weights;

  modport master (
    output start, mu_error, x_vec, freeze,
    input  busy, done, weights
  );

  modport slave (
    input  start, mu_error, x_vec, freeze,
    output busy, done, weights
  );

endinterface

// File: rtl/wu_mac_sat.sv
// Combinational single-tap LMS step: s = w - leak(w) + round(x * mu), with
// optional saturation (else wrap). A frozen tap passes w through unchanged.
module wu_mac_sat
  import saf_pkg::*;
#(
  parameter int unsigned WIDTH      = SafWidth,
  parameter int unsigned QP         = SafQp,
  parameter bit          SAT_EN     = 1'b1,
  parameter int unsigned LEAK_SHIFT = 0
) (
  input  logic signed [WIDTH-1:0] x_k_i,
  input  logic signed [WIDTH-1:0] mu_i,
  input  logic signed [WIDTH-1:0] w_k_i,
  input  logic                    freeze_i,
  output logic signed [WIDTH-1:0] s_o
);

  logic signed [2*WIDTH-1:0] p;
  saf_acc_t                  d_full;
  saf_acc_t                  d_clip;
  logic signed [WIDTH-1:0]   d;
  saf_acc_t                  leak;
  saf_acc_t                  s_full;
  saf_acc_t                  s_clip;

  always_comb begin
    p      = (2*WIDTH)'(x_k_i) * (2*WIDTH)'(mu_i);
    d_full = (saf_acc_t'(p) + rnd(QP)) >>> QP;
    d_clip = SAT_EN ? sat_to_width(d_full, WIDTH) : d_full;
    d      = WIDTH'(d_clip);

    leak = '0;
    if (LEAK_SHIFT != 0) begin
      leak = saf_acc_t'(w_k_i) >>> LEAK_SHIFT;
    end

    // The sum always fits in WIDTH+2 bits, so the wide accumulator clips and wraps identically.
    s_full = saf_acc_t'(w_k_i) - leak + saf_acc_t'(d);
    s_clip = SAT_EN ? sat_to_width(s_full, WIDTH) : s_full;
    s_o    = freeze_i ? w_k_i : WIDTH'(s_clip);
  end

endmodule

// File: rtl/w_update_bank.sv
// Bank of TAPS adaptive weights updated through one time-multiplexed MAC, one tap
// per cycle into a shadow copy; the whole set is committed in a single edge.
module w_update_bank
  import saf_pkg::*;
#(
  parameter int unsigned WIDTH      = SafWidth,
  parameter int unsigned QP         = SafQp,
  parameter int unsigned TAPS       = SafTaps,
  parameter int          RESET_VAL  = 0,
  parameter bit          SAT_EN     = 1'b1,
  parameter int unsigned LEAK_SHIFT = 0
) (
  input logic             clk,
  input logic             reset,
  w_update_bank_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(TAPS);

  typedef logic signed [WIDTH-1:0] word_t;

  localparam word_t RstWeight = WIDTH'(RESET_VAL <<< QP);

  wu_state_e        state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  word_t            mu_q, mu_d;
  logic             freeze_q, freeze_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  word_t            x_q[TAPS];
  word_t            x_d[TAPS];
  word_t            shadow_q[TAPS];
  word_t            shadow_d[TAPS];
  word_t            weights_q[TAPS];
  word_t            weights_d[TAPS];
  word_t            s;
  logic             last_tap;
  logic [TAPS*WIDTH-1:0] weights_flat;

  wu_mac_sat #(
    .WIDTH      (WIDTH),
    .QP         (QP),
    .SAT_EN     (SAT_EN),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_mac (
    .x_k_i    (x_q[idx_q]),
    .mu_i     (mu_q),
    .w_k_i    (shadow_q[idx_q]),
    .freeze_i (freeze_q),
    .s_o      (s)
  );

  assign last_tap = (idx_q == IdxW'(TAPS - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mu_d      = mu_q;
    freeze_d  = freeze_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    x_d       = x_q;
    shadow_d  = shadow_q;
    weights_d = weights_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StRun;
          busy_d   = 1'b1;
          idx_d    = '0;
          mu_d     = bus.mu_error;
          freeze_d = bus.freeze;
          shadow_d = weights_q;
          for (int unsigned k = 0; k < TAPS; k++) begin
            x_d[k] = bus.x_vec[k*WIDTH +: WIDTH];
          end
        end
      end
      StRun: begin
        shadow_d[idx_q] = s;
        idx_d           = idx_q + IdxW'(1);
        if (last_tap) begin
          // The last tap bypasses the shadow so the commit lands on the same edge.
          weights_d          = shadow_q;
          weights_d[TAPS-1]  = s;
          done_d             = 1'b1;
          busy_d             = 1'b0;
          state_d            = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      mu_q     <= '0;
      freeze_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int unsigned k = 0; k < TAPS; k++) begin
        x_q[k]       <= '0;
        shadow_q[k]  <= RstWeight;
        weights_q[k] <= RstWeight;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mu_q      <= mu_d;
      freeze_q  <= freeze_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      x_q       <= x_d;
      shadow_q  <= shadow_d;
      weights_q <= weights_d;
    end
  end

  always_comb begin
    weights_flat = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      weights_flat[k*WIDTH +: WIDTH] = weights_q[k];
    end
  end

  assign bus.weights = weights_flat;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_w_update_bank.sv
// Bench for w_update_bank: three instances (saturating, wrapping, leaky with
// RESET_VAL=1) share one stimulus stream and are checked against an arithmetic model.
module tb_w_update_bank;

  logic clk = 1'b0;
  logic reset;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  w_update_bank_if #(.WIDTH(16), .TAPS(4)) ifa ();
  w_update_bank_if #(.WIDTH(16), .TAPS(4)) ifw ();
  w_update_bank_if #(.WIDTH(16), .TAPS(4)) ifl ();

  assign ifw.start    = ifa.start;
  assign ifw.mu_error = ifa.mu_error;
  assign ifw.x_vec    = ifa.x_vec;
  assign ifw.freeze   = ifa.freeze;
  assign ifl.start    = ifa.start;
  assign ifl.mu_error = ifa.mu_error;
  assign ifl.x_vec    = ifa.x_vec;
  assign ifl.freeze   = ifa.freeze;

  w_update_bank #(.WIDTH(16), .QP(12), .TAPS(4), .RESET_VAL(0), .SAT_EN(1'b1),
                  .LEAK_SHIFT(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  w_update_bank #(.WIDTH(16), .QP(12), .TAPS(4), .RESET_VAL(0), .SAT_EN(1'b0),
                  .LEAK_SHIFT(0)) dut_w (.clk(clk), .reset(reset), .bus(ifw));
  w_update_bank #(.WIDTH(16), .QP(12), .TAPS(4), .RESET_VAL(1), .SAT_EN(1'b1),
                  .LEAK_SHIFT(4)) dut_l (.clk(clk), .reset(reset), .bus(ifl));

  longint wm[3][4];

  function automatic bit cfg_sat(int d);
    return d != 1;
  endfunction

  function automatic int cfg_leak(int d);
    return (d == 2) ? 4 : 0;
  endfunction

  function automatic longint cfg_rst(int d);
    return (d == 2) ? 64'sd4096 : 64'sd0;
  endfunction

  function automatic longint floor_div(longint a, longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic longint clip16(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint wrap16(longint v);
    longint r;
    r = v % 65536;
    if (r < 0) r = r + 65536;
    if (r >= 32768) r = r - 65536;
    return r;
  endfunction

  function automatic longint tap_model(longint w, longint x, longint mu, bit sat, int leak,
                                       bit frz);
    longint d;
    longint l;
    longint s;
    if (frz) return w;
    d = floor_div(x * mu + 2048, 4096);
    d = sat ? clip16(d) : wrap16(d);
    l = (leak != 0) ? floor_div(w, longint'(1) << leak) : 0;
    s = w - l + d;
    return sat ? clip16(s) : wrap16(s);
  endfunction

  task automatic model_update(input logic [15:0] mu, input logic [63:0] xv, input bit frz);
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 4; k++) begin
        wm[d][k] = tap_model(wm[d][k], longint'($signed(xv[k*16 +: 16])),
                             longint'($signed(mu)), cfg_sat(d), cfg_leak(d), frz);
      end
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 4; k++) wm[d][k] = cfg_rst(d);
    end
  endtask

  function automatic logic [63:0] model_vec(int d);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[k*16 +: 16] = 16'(wm[d][k]);
    return v;
  endfunction

  function automatic logic [63:0] dut_vec(int d);
    case (d)
      0:       return ifa.weights;
      1:       return ifw.weights;
      default: return ifl.weights;
    endcase
  endfunction

  function automatic logic dut_busy(int d);
    case (d)
      0:       return ifa.busy;
      1:       return ifw.busy;
      default: return ifl.busy;
    endcase
  endfunction

  function automatic logic dut_done(int d);
    case (d)
      0:       return ifa.done;
      1:       return ifw.done;
      default: return ifl.done;
    endcase
  endfunction

  function automatic logic [63:0] rand_x();
    return {$urandom, $urandom};
  endfunction

  // Issues one start, scrambles inputs after acceptance and waits (bounded) for done.
  task automatic run_update(input logic [15:0] mu, input logic [63:0] xv, input bit frz,
                            input int poke_cyc, output int lat, output bit busy_ok,
                            output bit hold_ok, output int done_cyc);
    logic [63:0] wa0, ww0, wl0;
    @(negedge clk);
    ifa.mu_error = mu;
    ifa.x_vec    = xv;
    ifa.freeze   = frz;
    ifa.start    = 1'b1;
    wa0 = ifa.weights;
    ww0 = ifw.weights;
    wl0 = ifl.weights;
    @(posedge clk);
    #1;
    ifa.start    = 1'b0;
    ifa.mu_error = 16'($urandom);
    ifa.x_vec    = rand_x();
    ifa.freeze   = 1'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    done_cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (ifa.done === 1'b1) begin
        lat = c;
        done_cyc = cyc;
        break;
      end
      if (ifa.busy !== 1'b1 || ifw.busy !== 1'b1 || ifl.busy !== 1'b1) busy_ok = 1'b0;
      if (ifa.weights !== wa0 || ifw.weights !== ww0 || ifl.weights !== wl0) hold_ok = 1'b0;
      if (c == poke_cyc) begin
        ifa.start    = 1'b1;
        ifa.mu_error = 16'($urandom);
        ifa.x_vec    = rand_x();
      end
      if (c == poke_cyc + 2) ifa.start = 1'b0;
    end
    ifa.start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    ifa.start    = 1'b0;
    ifa.mu_error = '0;
    ifa.x_vec    = '0;
    ifa.freeze   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (dut_busy(d) !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy dut%0d: got %b want 0", d, dut_busy(d));
      end
      checks++;
      if (dut_done(d) !== 1'b0) begin
        errors++;
        $display("FAIL reset_done dut%0d: got %b want 0", d, dut_done(d));
      end
      checks++;
      if (dut_vec(d) !== model_vec(d)) begin
        errors++;
        $display("FAIL reset_weights dut%0d: got %h want %h", d, dut_vec(d), model_vec(d));
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat, dc;
    bit bo, ho;
    run_update(16'd2048, {4{16'd4096}}, 1'b0, 0, lat, bo, ho, dc);
    model_update(16'd2048, {4{16'd4096}}, 1'b0);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 4", lat);
    end
    checks++;
    if (!bo) begin
      errors++;
      $display("FAIL basic_busy: got busy low before done want high for 4 cycles");
    end
    checks++;
    if (!ho) begin
      errors++;
      $display("FAIL basic_hold: got weights changed before commit want unchanged");
    end
    checks++;
    if (ifa.weights !== {4{16'd2048}} || ifw.weights !== {4{16'd2048}}) begin
      errors++;
      $display("FAIL basic_weights: got %h/%h want %h", ifa.weights, ifw.weights,
               {4{16'd2048}});
    end
    checks++;
    if (ifl.weights !== model_vec(2)) begin
      errors++;
      $display("FAIL basic_leak_weights: got %h want %h", ifl.weights, model_vec(2));
    end
    @(posedge clk);
    #1;
    checks++;
    if (ifa.done !== 1'b0 || ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b want 0 0", ifa.done, ifa.busy);
    end
  endtask

  task automatic test_rounding();
    int lat, dc;
    bit bo, ho;
    logic [63:0] xv;
    xv = {16'hF000, 16'h1000, 16'hF800, 16'h0800};
    do_reset();
    run_update(16'd1, xv, 1'b0, 0, lat, bo, ho, dc);
    model_update(16'd1, xv, 1'b0);
    checks++;
    if (ifa.weights !== {16'hFFFF, 16'h0001, 16'h0000, 16'h0001}) begin
      errors++;
      $display("FAIL rounding: got %h want %h", ifa.weights,
               {16'hFFFF, 16'h0001, 16'h0000, 16'h0001});
    end
    for (int d = 1; d < 3; d++) begin
      checks++;
      if (dut_vec(d) !== model_vec(d)) begin
        errors++;
        $display("FAIL rounding_model dut%0d: got %h want %h", d, dut_vec(d), model_vec(d));
      end
    end
  endtask

  task automatic test_saturation();
    int lat, dc;
    bit bo, ho;
    logic [63:0] xv;
    xv = {48'h0, 16'd4096};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      run_update(16'd16000, xv, 1'b0, 0, lat, bo, ho, dc);
      model_update(16'd16000, xv, 1'b0);
    end
    checks++;
    if (ifa.weights[15:0] !== 16'd32000 || ifw.weights[15:0] !== 16'd32000) begin
      errors++;
      $display("FAIL sat_preload: got %h/%h want %h", ifa.weights[15:0], ifw.weights[15:0],
               16'd32000);
    end
    run_update(16'd2048, xv, 1'b0, 0, lat, bo, ho, dc);
    model_update(16'd2048, xv, 1'b0);
    checks++;
    if (ifa.weights[15:0] !== 16'h7FFF) begin
      errors++;
      $display("FAIL sat_clip: got %h want 7fff", ifa.weights[15:0]);
    end
    checks++;
    if (ifw.weights[15:0] !== 16'h8500) begin
      errors++;
      $display("FAIL sat_wrap: got %h want 8500", ifw.weights[15:0]);
    end
    checks++;
    if (ifl.weights !== model_vec(2)) begin
      errors++;
      $display("FAIL sat_leak_model: got %h want %h", ifl.weights, model_vec(2));
    end
  endtask

  task automatic test_leakage();
    int lat, dc;
    bit bo, ho;
    logic [63:0] xv;
    do_reset();
    xv = rand_x();
    run_update(16'd0, xv, 1'b1, 0, lat, bo, ho, dc);
    model_update(16'd0, xv, 1'b1);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL leak_freeze_done: got latency %0d want 4", lat);
    end
    checks++;
    if (ifl.weights !== {4{16'd4096}}) begin
      errors++;
      $display("FAIL leak_freeze_hold: got %h want %h", ifl.weights, {4{16'd4096}});
    end
    xv = rand_x();
    run_update(16'd0, xv, 1'b0, 0, lat, bo, ho, dc);
    model_update(16'd0, xv, 1'b0);
    checks++;
    if (ifl.weights !== {4{16'd3840}}) begin
      errors++;
      $display("FAIL leak_step: got %h want %h", ifl.weights, {4{16'd3840}});
    end
  endtask

  task automatic test_start_during_run();
    int lat, dc;
    bit bo, ho, extra;
    logic [15:0] mu;
    logic [63:0] xv;
    mu = 16'($urandom);
    xv = rand_x();
    run_update(mu, xv, 1'b0, 1, lat, bo, ho, dc);
    model_update(mu, xv, 1'b0);
    extra = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ifa.done !== 1'b0 || ifa.busy !== 1'b0) extra = 1'b1;
    end
    checks++;
    if (lat != 4 || extra) begin
      errors++;
      $display("FAIL start_in_run: got latency %0d extra_activity %b want 4 0", lat, extra);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (dut_vec(d) !== model_vec(d)) begin
        errors++;
        $display("FAIL start_in_run_weights dut%0d: got %h want %h", d, dut_vec(d),
                 model_vec(d));
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat0, lat1, dc0, dc1;
    bit bo, ho;
    logic [15:0] mu0, mu1;
    logic [63:0] xv0, xv1;
    mu0 = 16'($urandom);
    mu1 = 16'($urandom);
    xv0 = rand_x();
    xv1 = rand_x();
    run_update(mu0, xv0, 1'b0, 0, lat0, bo, ho, dc0);
    model_update(mu0, xv0, 1'b0);
    run_update(mu1, xv1, 1'b0, 0, lat1, bo, ho, dc1);
    model_update(mu1, xv1, 1'b0);
    checks++;
    if (lat0 != 4 || lat1 != 4 || dc1 - dc0 != 5) begin
      errors++;
      $display("FAIL back_to_back: got gap %0d (lat %0d,%0d) want gap 5", dc1 - dc0, lat0,
               lat1);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (dut_vec(d) !== model_vec(d)) begin
        errors++;
        $display("FAIL back_to_back_weights dut%0d: got %h want %h", d, dut_vec(d),
                 model_vec(d));
      end
    end
  endtask

  task automatic test_reset_during_run();
    int lat, dc;
    bit bo, ho, seen_done;
    logic [15:0] mu;
    logic [63:0] xv;
    mu = 16'd3000;
    xv = {4{16'd4096}};
    run_update(mu, xv, 1'b0, 0, lat, bo, ho, dc);
    model_update(mu, xv, 1'b0);
    @(negedge clk);
    ifa.mu_error = 16'($urandom);
    ifa.x_vec    = rand_x();
    ifa.freeze   = 1'b0;
    ifa.start    = 1'b1;
    @(posedge clk);
    #1;
    ifa.start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    checks++;
    if (ifa.busy !== 1'b0 || ifw.busy !== 1'b0 || ifl.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_run_busy: got %b%b%b want 000", ifa.busy, ifw.busy, ifl.busy);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (dut_vec(d) !== model_vec(d)) begin
        errors++;
        $display("FAIL rst_run_weights dut%0d: got %h want %h", d, dut_vec(d), model_vec(d));
      end
    end
    seen_done = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ifa.done !== 1'b0 || ifw.done !== 1'b0 || ifl.done !== 1'b0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL rst_run_no_done: got done pulse want none");
    end
    mu = 16'($urandom);
    xv = rand_x();
    run_update(mu, xv, 1'b0, 0, lat, bo, ho, dc);
    model_update(mu, xv, 1'b0);
    checks++;
    if (lat != 4 || dut_vec(0) !== model_vec(0)) begin
      errors++;
      $display("FAIL rst_run_restart: got lat %0d weights %h want 4 %h", lat, dut_vec(0),
               model_vec(0));
    end
  endtask

  task automatic test_random();
    int lat, dc;
    bit bo, ho, frz;
    logic [15:0] mu;
    logic [63:0] xv;
    for (int i = 0; i < 30; i++) begin
      mu  = (i % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
      xv  = rand_x();
      frz = ($urandom_range(0, 7) == 0);
      run_update(mu, xv, frz, 0, lat, bo, ho, dc);
      model_update(mu, xv, frz);
      checks++;
      if (lat != 4 || !bo || !ho) begin
        errors++;
        $display("FAIL random_handshake it%0d: got lat %0d busy_ok %b hold_ok %b want 4 1 1",
                 i, lat, bo, ho);
      end
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (dut_vec(d) !== model_vec(d)) begin
          errors++;
          $display("FAIL random_weights it%0d dut%0d: got %h want %h", i, d, dut_vec(d),
                   model_vec(d));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_leakage();
    test_start_during_run();
    test_back_to_back();
    test_reset_during_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
